// File: rtl/hit_detector_if.sv
// Purpose: groups the hit detector's frame/pixel inputs and status outputs into one bundle.
// Latency: none, wires only.
// Backpressure: none; every signal is sampled or driven every clk.
// Signals: startOfFrame, playerDR, obstacleDR, restart (towards the detector);
//          collision, livesLeft[3:0], invulnerable, gameOver (from the detector).
// Modports: master drives the inputs and observes status; slave is the detector side.
interface hit_detector_if;
  logic       startOfFrame;
  logic       playerDR;
  logic       obstacleDR;
  logic       restart;
  logic       collision;
  logic [3:0] livesLeft;
  logic       invulnerable;
  logic       gameOver;

  modport master (
    output startOfFrame, playerDR, obstacleDR, restart,
    input  collision, livesLeft, invulnerable, gameOver
  );

  modport slave (
    input  startOfFrame, playerDR, obstacleDR, restart,
    output collision, livesLeft, invulnerable, gameOver
  );
endinterface

// File: rtl/hit_detector.sv
// Purpose: per-frame player/obstacle overlap arbiter with lives, cooldown and game-over tracking.
// Latency: overlap in frame N gives a one-clk collision pulse 1 clk after frame N+1's startOfFrame.
// Backpressure: none; inputs are consumed every clk and outputs are always valid.
// Ports: clk, resetN (async, active-low); bus (hit_detector_if.slave):
//   in  startOfFrame, playerDR, obstacleDR, restart (sync clear)
//   out collision, livesLeft[3:0], invulnerable, gameOver
// Optional build macro HIT_PIXEL_THRESHOLD_EN: replaces the 1-bit overlap flag by a
// saturating 12-bit overlap counter compared against PIXEL_THRESHOLD.
module hit_detector #(
  parameter int COOLDOWN_FRAMES = 30,
  parameter int MAX_LIVES       = 3,
  parameter int PIXEL_THRESHOLD = 8
) (
  input  logic           clk,
  input  logic           resetN,
  hit_detector_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,
    ST_HIT      = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_GAMEOVER = 2'd3
  } state_e;

  localparam logic [3:0] LIVES_INIT = 4'(MAX_LIVES);
  localparam logic [7:0] COOL_INIT  = 8'(COOLDOWN_FRAMES);

  state_e     state_q, state_d;
  logic [3:0] lives_q, lives_d;
  logic [7:0] cool_q,  cool_d;

  logic overlap;
  logic sof;
  logic cool_done;
  logic accum_en;
  logic hit_pending;

  assign sof     = bus.startOfFrame;
  assign overlap = bus.playerDR & bus.obstacleDR;

  // The frame pulse that empties the cooldown counter also re-arms accumulation,
  // so an overlap on that very cycle already counts toward the new frame.
  assign cool_done = (state_q == ST_COOLDOWN) && sof && (cool_q <= 8'd1);
  assign accum_en  = (state_q == ST_ARMED) || cool_done;

`ifdef HIT_PIXEL_THRESHOLD_EN
  localparam logic [11:0] THRESH = 12'(PIXEL_THRESHOLD);

  logic [11:0] ovl_cnt_q, ovl_cnt_d;

  // Evaluation uses the count from before this cycle; the count restarts at
  // this cycle's overlap when a frame begins.
  assign hit_pending = (ovl_cnt_q >= THRESH);

  always_comb begin
    ovl_cnt_d = ovl_cnt_q;
    if (bus.restart) begin
      ovl_cnt_d = 12'd0;
    end else if (sof) begin
      ovl_cnt_d = {11'd0, accum_en & overlap};
    end else if (accum_en && overlap && (ovl_cnt_q != 12'hFFF)) begin
      ovl_cnt_d = ovl_cnt_q + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ovl_cnt_q <= 12'd0;
    end else begin
      ovl_cnt_q <= ovl_cnt_d;
    end
  end
`else
  logic ovl_flag_q, ovl_flag_d;

  // Any overlapping pixel is a hit; legal thresholds are >= 1, so the
  // comparison below is constant-true and only documents the equivalence.
  assign hit_pending = ovl_flag_q && (PIXEL_THRESHOLD > 0);

  always_comb begin
    ovl_flag_d = ovl_flag_q;
    if (bus.restart) begin
      ovl_flag_d = 1'b0;
    end else if (sof) begin
      ovl_flag_d = accum_en & overlap;
    end else if (accum_en && overlap) begin
      ovl_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ovl_flag_q <= 1'b0;
    end else begin
      ovl_flag_q <= ovl_flag_d;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_ARMED;
      lives_q <= LIVES_INIT;
      cool_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      cool_q  <= cool_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    cool_d  = cool_q;
    if (bus.restart) begin
      state_d = ST_ARMED;
      lives_d = LIVES_INIT;
      cool_d  = 8'd0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (sof && hit_pending && (lives_q != 4'd0)) begin
            state_d = ST_HIT;
            lives_d = lives_q - 4'd1;
          end
        end
        ST_HIT: begin
          // lives_q already holds the decremented count here.
          if (lives_q == 4'd0) begin
            state_d = ST_GAMEOVER;
          end else if (COOLDOWN_FRAMES == 0) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_COOLDOWN;
            cool_d  = COOL_INIT;
          end
        end
        ST_COOLDOWN: begin
          if (cool_done) begin
            state_d = ST_ARMED;
            cool_d  = 8'd0;
          end else if (sof) begin
            cool_d = cool_q - 8'd1;
          end
        end
        ST_GAMEOVER: begin
          state_d = ST_GAMEOVER;
        end
        default: begin
          state_d = ST_ARMED;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    bus.collision    = (state_q == ST_HIT);
    bus.invulnerable = (state_q == ST_COOLDOWN);
    bus.gameOver     = (state_q == ST_GAMEOVER);
    bus.livesLeft    = lives_q;
  end

endmodule

// File: tb/tb_hit_detector.sv
// Purpose: self-checking bench for hit_detector against a frame-level model.
// Latency: model predicts outputs for the clk after each sampled input cycle.
// Backpressure: none; bench drives inputs on falling edges.
module tb_hit_detector;
  localparam int CD   = 30;
  localparam int ML   = 3;
  localparam int THR  = 8;
  localparam int FLEN = 12;

  logic clk = 1'b0;
  logic resetN;
  hit_detector_if bus ();

  hit_detector #(
    .COOLDOWN_FRAMES(CD),
    .MAX_LIVES      (ML),
    .PIXEL_THRESHOLD(THR)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;
  int n_coll = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: lives remaining, frames of invulnerability left,
  // overlaps seen in the current frame, and whether this clk carries a pulse.
  int m_lives;
  int m_inv;
  int m_cnt;
  bit m_hit;
  bit m_over;

  function automatic bit pend(input int c);
`ifdef HIT_PIXEL_THRESHOLD_EN
    return c >= THR;
`else
    return c > 0;
`endif
  endfunction

  always @(posedge clk or negedge resetN) begin : model
    bit sof;
    bit ov;
    sof = bus.startOfFrame;
    ov  = bus.playerDR && bus.obstacleDR;
    if (!resetN || bus.restart) begin
      m_lives = ML; m_inv = 0; m_cnt = 0; m_hit = 0; m_over = 0;
    end else if (m_hit) begin
      m_hit = 0;
      if (m_lives == 0) m_over = 1;
      else if (CD > 0) m_inv = CD;
      if (sof) m_cnt = 0;
    end else if (m_over) begin
      m_cnt = m_cnt;
    end else if (m_inv > 0) begin
      if (sof) begin
        m_inv = m_inv - 1;
        m_cnt = (m_inv == 0 && ov) ? 1 : 0;
      end
    end else begin
      if (sof) begin
        if (pend(m_cnt)) begin
          m_hit   = 1;
          m_lives = m_lives - 1;
        end
        m_cnt = ov ? 1 : 0;
      end else if (ov && m_cnt < 4095) begin
        m_cnt = m_cnt + 1;
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_collision",    bus.collision,    m_hit);
      chk("cyc_livesLeft",    bus.livesLeft,    m_lives);
      chk("cyc_invulnerable", bus.invulnerable, m_inv > 0);
      chk("cyc_gameOver",     bus.gameOver,     m_over);
      if (bus.collision) n_coll++;
    end
  end

  task automatic drive(input bit sof, input bit p, input bit o);
    @(negedge clk);
    bus.startOfFrame = sof;
    bus.playerDR     = p;
    bus.obstacleDR   = o;
    bus.restart      = 1'b0;
  endtask

  task automatic sof_cycle(input bit ov);
    drive(1'b1, ov, ov);
  endtask

  // Rest of a frame: n overlap pixels, then one player-only and one obstacle-only pixel.
  task automatic body(input int n);
    for (int i = 1; i < FLEN; i++)
      drive(1'b0, (i <= n) || (i == FLEN - 1), (i <= n) || (i == FLEN - 2));
  endtask

  task automatic frames(input int k, input int n);
    for (int f = 0; f < k; f++) begin
      sof_cycle(1'b0);
      body(n);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    bus.playerDR     = 1'b0;
    bus.obstacleDR   = 1'b0;
    bus.restart      = 1'b1;
  endtask

  initial begin
    resetN           = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.playerDR     = 1'b0;
    bus.obstacleDR   = 1'b0;
    bus.restart      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_collision", bus.collision, 0);
    chk("rst_lives", bus.livesLeft, 3);
    chk("rst_inv", bus.invulnerable, 0);
    chk("rst_gameover", bus.gameOver, 0);
    chk_on = 1'b1;
    #2 resetN = 1'b1;

    // Quiet frames
    frames(5, 0);
    after_edge();
    chk("quiet_lives", bus.livesLeft, 3);
    chk("quiet_inv", bus.invulnerable, 0);

    // Single overlap pixel, then 30 frames of cooldown
    frames(1, 1);
    sof_cycle(1'b0);
    after_edge();
    chk("hit1_collision", bus.collision, 1);
    chk("hit1_lives", bus.livesLeft, 2);
    drive(1'b0, 1'b0, 1'b0);
    after_edge();
    chk("hit1_pulse_end", bus.collision, 0);
    chk("hit1_inv", bus.invulnerable, 1);
    body(0);
    frames(29, 0);
    after_edge();
    chk("cool29_inv", bus.invulnerable, 1);
    sof_cycle(1'b0);
    after_edge();
    chk("cool30_inv", bus.invulnerable, 0);
    body(0);

    // Overlap only on the startOfFrame cycle counts for the next frame
    sof_cycle(1'b1);
    after_edge();
    chk("sofovl_no_pulse", bus.collision, 0);
    body(0);
    sof_cycle(1'b0);
    after_edge();
    chk("sofovl_pulse", bus.collision, 1);
    chk("sofovl_lives", bus.livesLeft, 1);
    body(0);

    // Async reset with 12 cooldown frames remaining
    frames(18, 0);
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    chk("midrst_lives", bus.livesLeft, 3);
    chk("midrst_inv", bus.invulnerable, 0);
    @(negedge clk);
    #2 resetN = 1'b1;
    frames(1, 1);
    sof_cycle(1'b0);
    after_edge();
    chk("postrst_collision", bus.collision, 1);
    chk("postrst_lives", bus.livesLeft, 2);
    body(0);

    // Threshold: 7 overlaps, then 8
    frames(30, 0);
    after_edge();
    chk("thr_armed_inv", bus.invulnerable, 0);
    frames(1, 7);
    sof_cycle(1'b0);
    after_edge();
`ifdef HIT_PIXEL_THRESHOLD_EN
    chk("thr7_collision", bus.collision, 0);
    chk("thr7_lives", bus.livesLeft, 2);
`else
    chk("thr7_collision", bus.collision, 1);
    chk("thr7_lives", bus.livesLeft, 1);
`endif
    body(8);
    sof_cycle(1'b0);
    after_edge();
`ifdef HIT_PIXEL_THRESHOLD_EN
    chk("thr8_collision", bus.collision, 1);
`else
    chk("thr8_collision", bus.collision, 0);
`endif
    chk("thr8_lives", bus.livesLeft, 1);
    body(0);

    // Restart in the middle of cooldown
    pulse_restart();
    after_edge();
    chk("rs_cool_inv", bus.invulnerable, 0);
    chk("rs_cool_lives", bus.livesLeft, 3);

    // Continuous overlap until game over
    n_coll = 0;
    frames(63, 9);
    sof_cycle(1'b0);
    after_edge();
    chk("go_last_pulse", bus.collision, 1);
    chk("go_lives", bus.livesLeft, 0);
    body(9);
    after_edge();
    chk("go_flag", bus.gameOver, 1);
    frames(3, 9);
    after_edge();
    chk("go_pulse_count", n_coll, 3);
    chk("go_lives_hold", bus.livesLeft, 0);

    // Restart from game over
    pulse_restart();
    after_edge();
    chk("rs_go_flag", bus.gameOver, 0);
    chk("rs_go_lives", bus.livesLeft, 3);

    // Back-to-back startOfFrame while in HIT
    frames(1, 2);
    sof_cycle(1'b0);
    sof_cycle(1'b1);
    after_edge();
    chk("b2b_collision", bus.collision, 0);
    chk("b2b_inv", bus.invulnerable, 1);
    chk("b2b_lives", bus.livesLeft, 2);
    body(0);
    frames(31, 3);
    after_edge();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hit_detector.md
Name: hit_detector

Overview:
- Per-pixel collision arbiter sitting directly upstream of the player mover; drives the mover's `collision` input.
- Watches the player and obstacle drawing requests during the raster scan and accumulates overlap over each frame.
- At frame boundary it issues at most one single-cycle collision pulse, then enforces an invulnerability cooldown.
- Tracks remaining lives and flags game over.

Parameters:
- COOLDOWN_FRAMES, 30, frames of invulnerability after a hit (0..255).
- MAX_LIVES, 3, lives loaded at reset/restart (1..15).
- PIXEL_THRESHOLD, 8, overlapping pixels per frame required for a hit (only with HIT_PIXEL_THRESHOLD_EN; 1..4095).

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous reset, active-low
- startOfFrame  in  1  one-clk pulse at start of each frame (30 Hz)
- playerDR  in  1  player drawing request for current pixel
- obstacleDR  in  1  obstacle drawing request for current pixel
- restart  in  1  synchronous clear to reset state, one clk pulse
- collision  out  1  one-clk hit pulse to mover
- livesLeft  out  4  remaining lives
- invulnerable  out  1  high while in COOLDOWN
- gameOver  out  1  high in GAMEOVER state

Behaviour:
- Reset values: collision=0, livesLeft=MAX_LIVES, invulnerable=0, gameOver=0, state=ARMED, overlap flag/counter=0, cooldown counter=0.
- Priority: resetN > restart > startOfFrame processing > pixel accumulation.
- restart: same state as reset on the next edge; takes effect even mid-COOLDOWN or while in GAMEOVER.
- Overlap definition: a cycle with playerDR && obstacleDR.
  - In ARMED, each overlap sets the pending flag. With the optional feature, it instead increments a 12-bit counter that saturates at 4095.
  - In all other states overlaps are ignored.
- Frame boundary: on a cycle with startOfFrame=1, the pending evaluation uses the flag/counter value accumulated before that cycle. The flag/counter is then cleared.
  - An overlap on the startOfFrame cycle itself counts toward the new frame.
- State machine:
  - ARMED -> HIT when startOfFrame && hit pending.
  - HIT: lasts exactly one clk.
    - collision=1 and livesLeft decrements (registered, both visible the cycle after the startOfFrame).
    - Next state is GAMEOVER if the decremented livesLeft==0.
    - Else, if COOLDOWN_FRAMES==0, next state is ARMED.
    - Otherwise next state is COOLDOWN, with the cooldown counter loaded with COOLDOWN_FRAMES.
  - COOLDOWN: invulnerable=1.
    - Each startOfFrame decrements the counter.
    - The startOfFrame that makes the counter reach 0 moves to ARMED; accumulation starts fresh from that cycle.
  - GAMEOVER: gameOver=1, collision never asserted, livesLeft=0; exits only via restart/reset.
- Latency: hit on frame N -> collision pulse 1 clk after frame N+1's startOfFrame.
- collision is never high for two consecutive cycles. At most one pulse per frame.
- livesLeft never underflows.
- startOfFrame arriving during HIT (back-to-back pulses) is ignored for hit evaluation but still clears the accumulator.

Optional Feature:
- Macro HIT_PIXEL_THRESHOLD_EN.
- Defined: hit pending when the overlap counter >= PIXEL_THRESHOLD at frame boundary. This filters single-pixel grazes.
- Undefined: no counter logic; hit pending when any overlap pixel occurred (1-bit flag); PIXEL_THRESHOLD unused.

Test Plan:
- After reset, 5 frames with no overlap -> collision stays 0, livesLeft=3, invulnerable=0.
- Frame with 1 overlap pixel (macro undefined) -> collision=1 for exactly one clk after the next startOfFrame; livesLeft=2; invulnerable=1 for the following 30 startOfFrame pulses, then 0.
- Continuous overlap every frame, COOLDOWN_FRAMES=2, MAX_LIVES=3 -> pulses spaced 3 frames apart; after the 3rd pulse gameOver=1, livesLeft=0, no further pulses; restart -> livesLeft=3, gameOver=0, state ARMED.
- Overlap only on the startOfFrame cycle -> no pulse at that boundary; pulse at the following boundary.
- Macro defined, PIXEL_THRESHOLD=8: frame with 7 overlaps -> no collision; frame with 8 -> collision pulse, livesLeft decrements.
- resetN asserted mid-COOLDOWN (counter=12) -> immediate reset values; first overlap frame afterwards produces a normal hit.
